// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Returns the even-parity bit for a data byte (1 when the byte has an odd number of ones).
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage; push while full is accepted only with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (int'(level_q) == DEPTH);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and fill level; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_rx_8e1.sv
// 8E1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM, receive FIFO and sticky error flags.
module uart_rx_8e1
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          io_clk,
    input  logic                          io_nreset,
    input  logic [DIV_WIDTH-1:0]          divisor,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clear_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);

    rx_state_t                 state_q, state_d;
    logic                      sync1_q, sync1_d;
    logic                      sync2_q, sync2_d;
    logic [DIV_WIDTH-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      perr_q, perr_d;
    logic                      parity_err_q, parity_err_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    logic rs;
    logic push_req;
    logic parity_set;
    logic frame_set;
    logic overrun_set;
    logic fifo_full;
    logic fifo_empty;

    assign rs         = sync2_q;
    assign rx_valid   = !fifo_empty;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (io_clk),
        .nreset    (io_nreset),
        .push      (push_req),
        .push_data (shift_q),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Frame FSM, bit timer and sticky flag update; a set in the same cycle as clear_err wins.
    always_comb begin
        sync1_d     = rx;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        perr_d      = perr_q;
        push_req    = 1'b0;
        parity_set  = 1'b0;
        frame_set   = 1'b0;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!rs) begin
                    cnt_d   = divisor >> 1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rs) begin
                        cnt_d   = divisor;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rs;
                    cnt_d          = divisor;
                    if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    perr_d  = rs ^ even_parity(shift_q);
                    cnt_d   = divisor;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rs) begin
                        push_req   = 1'b1;
                        parity_set = perr_q;
                        state_d    = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overrun_set  = push_req && fifo_full && !rx_ready;
        parity_err_d = (parity_err_q && !clear_err) || parity_set;
        frame_err_d  = (frame_err_q && !clear_err) || frame_set;
        overrun_d    = (overrun_q && !clear_err) || overrun_set;
    end

    // State, timer, synchronizer and flag registers; synchronizer resets to the idle line level.
    always_ff @(posedge io_clk) begin
        if (!io_nreset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_8e1.sv
// Directed bench for uart_rx_8e1: drives 8E1 frames at 6 clocks per bit and checks delivery and flags.
module tb_uart_rx_8e1;

    logic        io_clk    = 1'b0;
    logic        io_nreset = 1'b0;
    logic [15:0] divisor   = 16'd5;
    logic        rx        = 1'b1;
    logic        rx_ready  = 1'b0;
    logic        clear_err = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic [2:0]  fifo_level;

    int          check_count = 0;
    int          pass_count  = 0;
    int          fail_count  = 0;
    int          pop_count   = 0;
    int          pops_before = 0;
    logic [7:0]  last_pop    = 8'h00;
    logic [4:0]  par5        = 5'b01011;

    uart_rx_8e1 #(
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (16)
    ) dut (
        .io_clk     (io_clk),
        .io_nreset  (io_nreset),
        .divisor    (divisor),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clear_err  (clear_err),
        .fifo_level (fifo_level)
    );

    always #5 io_clk = ~io_clk;

    // Records every byte the consumer side actually pops.
    always @(posedge io_clk) begin
        if (io_nreset && rx_valid && rx_ready) begin
            pop_count <= pop_count + 1;
            last_pop  <= rx_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge io_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic level, input int clocks);
        rx = level;
        tick(clocks);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic par, input int stop_low);
        applyStimulus(1'b0, 6);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(data[i], 6);
        end
        applyStimulus(par, 6);
        if (stop_low > 0) begin
            applyStimulus(1'b0, stop_low);
        end
        applyStimulus(1'b1, 6);
        applyStimulus(1'b1, 4);
    endtask

    initial begin
        $display("[TB] starting uart_rx_8e1 bench");
        tick(3);
        checkOutput("rst_valid", rx_valid, 1'b0);
        checkOutput("rst_data", rx_data, 8'h00);
        checkOutput("rst_level", fifo_level, 3'd0);
        checkOutput("rst_perr", parity_err, 1'b0);
        checkOutput("rst_ferr", frame_err, 1'b0);
        checkOutput("rst_ovr", overrun, 1'b0);
        io_nreset = 1'b1;
        tick(4);

        $display("[TB] test 1: 0x55 good parity");
        rx_ready    = 1'b1;
        pops_before = pop_count;
        sendFrame(8'h55, 1'b0, 0);
        checkOutput("t1_pops", pop_count - pops_before, 1);
        checkOutput("t1_data", last_pop, 8'h55);
        checkOutput("t1_valid_low", rx_valid, 1'b0);
        checkOutput("t1_perr", parity_err, 1'b0);
        checkOutput("t1_ferr", frame_err, 1'b0);
        checkOutput("t1_ovr", overrun, 1'b0);

        $display("[TB] test 2: 0xA7 bad parity");
        pops_before = pop_count;
        sendFrame(8'hA7, 1'b0, 0);
        checkOutput("t2_pops", pop_count - pops_before, 1);
        checkOutput("t2_data", last_pop, 8'hA7);
        checkOutput("t2_perr_set", parity_err, 1'b1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        tick(1);
        checkOutput("t2_perr_clr", parity_err, 1'b0);

        $display("[TB] test 3: short low stop bit then 0x3C");
        pops_before = pop_count;
        sendFrame(8'h99, 1'b0, 4);
        checkOutput("t3_ferr", frame_err, 1'b1);
        checkOutput("t3_no_push", pop_count - pops_before, 0);
        checkOutput("t3_level", fifo_level, 3'd0);
        checkOutput("t3_perr", parity_err, 1'b0);
        sendFrame(8'h3C, 1'b0, 0);
        checkOutput("t3_pops", pop_count - pops_before, 1);
        checkOutput("t3_data", last_pop, 8'h3C);

        $display("[TB] test 4: 2-clock glitch");
        pops_before = pop_count;
        clear_err   = 1'b1;
        tick(1);
        clear_err   = 1'b0;
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 12);
        checkOutput("t4_no_push", pop_count - pops_before, 0);
        checkOutput("t4_level", fifo_level, 3'd0);
        checkOutput("t4_ferr", frame_err, 1'b0);
        checkOutput("t4_perr", parity_err, 1'b0);
        sendFrame(8'h5A, 1'b0, 0);
        checkOutput("t4_after_data", last_pop, 8'h5A);

        $display("[TB] test 5: fill FIFO and overrun");
        rx_ready    = 1'b0;
        pops_before = pop_count;
        for (int b = 0; b < 5; b++) begin
            sendFrame(8'(b + 1), par5[b], 0);
        end
        checkOutput("t5_level", fifo_level, 3'd4);
        checkOutput("t5_ovr", overrun, 1'b1);
        checkOutput("t5_perr", parity_err, 1'b0);
        checkOutput("t5_valid", rx_valid, 1'b1);
        for (int j = 0; j < 4; j++) begin
            checkOutput("t5_drain_data", rx_data, 8'(j + 1));
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        checkOutput("t5_drain_pops", pop_count - pops_before, 4);
        checkOutput("t5_empty_level", fifo_level, 3'd0);
        checkOutput("t5_empty_valid", rx_valid, 1'b0);

        $display("[TB] test 6: reset mid-frame then 0x42");
        rx_ready    = 1'b1;
        pops_before = pop_count;
        checkOutput("t6_pre_ovr", overrun, 1'b1);
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 6);
        applyStimulus(1'b0, 3);
        rx        = 1'b1;
        io_nreset = 1'b0;
        tick(2);
        checkOutput("t6_rst_valid", rx_valid, 1'b0);
        checkOutput("t6_rst_data", rx_data, 8'h00);
        checkOutput("t6_rst_level", fifo_level, 3'd0);
        checkOutput("t6_rst_perr", parity_err, 1'b0);
        checkOutput("t6_rst_ferr", frame_err, 1'b0);
        checkOutput("t6_rst_ovr", overrun, 1'b0);
        io_nreset = 1'b1;
        applyStimulus(1'b1, 70);
        checkOutput("t6_partial_lost", pop_count - pops_before, 0);
        sendFrame(8'h42, 1'b0, 0);
        checkOutput("t6_pops", pop_count - pops_before, 1);
        checkOutput("t6_data", last_pop, 8'h42);
        checkOutput("t6_ferr", frame_err, 1'b0);
        checkOutput("t6_perr", parity_err, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
